// File: rtl/slave_sync_addr_fifo.sv
// Single-clock AXI4 slave address-channel FIFO with valid/ready on both sides,
// optional first-word-fall-through output stage, exact water level and almost flags.
module slave_sync_addr_fifo #(
   parameter int DATA_WIDTH       = 46,
   parameter int DEPTH_WIDTH      = 6,
   parameter int ALMOST_FULL_NUM  = 60,
   parameter int ALMOST_EMPTY_NUM = 4,
   parameter int FWFT             = 1
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   flush,
   input  logic [DATA_WIDTH-1:0]  s_data,
   input  logic                   s_valid,
   output logic                   s_ready,
   output logic [DATA_WIDTH-1:0]  m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [DEPTH_WIDTH:0]   water_level,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic                   rd_underflow
);

   localparam int LW = DEPTH_WIDTH + 1;
   localparam logic [LW-1:0] LEVEL_FULL = LW'(1 << DEPTH_WIDTH);
   localparam logic [LW-1:0] LEVEL_AF   = LW'(ALMOST_FULL_NUM);
   localparam logic [LW-1:0] LEVEL_AE   = LW'(ALMOST_EMPTY_NUM);

   logic [DATA_WIDTH-1:0]  mem_q [1 << DEPTH_WIDTH];
   logic [DEPTH_WIDTH-1:0] wrPtr_q, wrPtr_d;
   logic [DEPTH_WIDTH-1:0] rdPtr_q, rdPtr_d;
   logic [LW-1:0]          level_q, level_d;
   logic [DATA_WIDTH-1:0]  mData_q, mData_d;
   logic                   mValid_q, mValid_d;
   logic                   underflow_q, underflow_d;
   logic                   readyEn_q;
   logic                   push, pop, memHasData;

   assign full         = (level_q == LEVEL_FULL);
   assign empty        = (level_q == '0);
   assign almost_full  = (level_q >= LEVEL_AF);
   assign almost_empty = (level_q <= LEVEL_AE);
   assign s_ready      = !full && readyEn_q;
   assign m_data       = mData_q;
   assign m_valid      = mValid_q;
   assign water_level  = level_q;
   assign rd_underflow = underflow_q;

   // In FWFT mode the output stage holds one of the counted entries, so the
   // array still has data only while the level exceeds the stage occupancy.
   assign memHasData = (level_q > LW'(mValid_q));

   always_comb begin
      wrPtr_d     = wrPtr_q;
      rdPtr_d     = rdPtr_q;
      level_d     = level_q;
      mData_d     = mData_q;
      mValid_d    = mValid_q;
      underflow_d = underflow_q;
      push        = s_valid && s_ready;
      pop         = 1'b0;

      if (FWFT != 0) begin
         pop = mValid_q && m_ready;
         if (!mValid_q || pop) begin
            if (memHasData) begin
               mValid_d = 1'b1;
               mData_d  = mem_q[rdPtr_q];
               rdPtr_d  = rdPtr_q + DEPTH_WIDTH'(1);
            end else begin
               mValid_d = 1'b0;
            end
         end
      end else begin
         pop      = m_ready && !empty;
         mValid_d = pop;
         if (pop) begin
            mData_d = mem_q[rdPtr_q];
            rdPtr_d = rdPtr_q + DEPTH_WIDTH'(1);
         end
         if (m_ready && empty) begin
            underflow_d = 1'b1;
         end
      end

      if (push) begin
         wrPtr_d = wrPtr_q + DEPTH_WIDTH'(1);
      end
      if (push && !pop) begin
         level_d = level_q + LW'(1);
      end else if (!push && pop) begin
         level_d = level_q - LW'(1);
      end

      if (flush) begin
         wrPtr_d     = '0;
         rdPtr_d     = '0;
         level_d     = '0;
         mData_d     = '0;
         mValid_d    = 1'b0;
         underflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         level_q     <= '0;
         mData_q     <= '0;
         mValid_q    <= 1'b0;
         underflow_q <= 1'b0;
         readyEn_q   <= 1'b0;
      end else begin
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         level_q     <= level_d;
         mData_q     <= mData_d;
         mValid_q    <= mValid_d;
         underflow_q <= underflow_d;
         readyEn_q   <= 1'b1;
      end
   end

   // Storage needs no reset; pointers and level define which words are live.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_q[wrPtr_q] <= s_data;
      end
   end

endmodule

// File: tb/tb_slave_sync_addr_fifo.sv
// Scoreboard bench for slave_sync_addr_fifo: one FWFT instance and one standard
// instance, directed stimulus with expected words queued and checked by monitors.
module tb_slave_sync_addr_fifo;

   logic clk = 1'b0;
   logic rstn;

   logic        aFlush, aSValid, aMReady;
   logic [45:0] aSData;
   logic        aSReady, aMValid, aFull, aEmpty, aAF, aAE, aUnder;
   logic [45:0] aMData;
   logic [6:0]  aLevel;

   logic        bFlush, bSValid, bMReady;
   logic [45:0] bSData;
   logic        bSReady, bMValid, bFull, bEmpty, bAF, bAE, bUnder;
   logic [45:0] bMData;
   logic [6:0]  bLevel;

   logic [45:0] aExpQ[$];
   logic [45:0] bExpQ[$];
   int assertCount = 0;
   int failCount   = 0;
   int aPopCnt     = 0;

   always #5 clk = ~clk;

   slave_sync_addr_fifo #(.FWFT(1)) dutFwft (
      .clk(clk), .rstn(rstn), .flush(aFlush),
      .s_data(aSData), .s_valid(aSValid), .s_ready(aSReady),
      .m_data(aMData), .m_valid(aMValid), .m_ready(aMReady),
      .water_level(aLevel), .full(aFull), .empty(aEmpty),
      .almost_full(aAF), .almost_empty(aAE), .rd_underflow(aUnder)
   );

   slave_sync_addr_fifo #(.FWFT(0)) dutStd (
      .clk(clk), .rstn(rstn), .flush(bFlush),
      .s_data(bSData), .s_valid(bSValid), .s_ready(bSReady),
      .m_data(bMData), .m_valid(bMValid), .m_ready(bMReady),
      .water_level(bLevel), .full(bFull), .empty(bEmpty),
      .almost_full(bAF), .almost_empty(bAE), .rd_underflow(bUnder)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: actual %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one instance's inputs; an accepted push is queued as an expected output.
   task automatic applyStimulus(input bit inst, input logic sValid, input logic [45:0] data,
                                input logic mReady, input logic flushIn, input bit expectPush);
      if (inst == 1'b0) begin
         aSValid = sValid; aSData = data; aMReady = mReady; aFlush = flushIn;
         if (expectPush) aExpQ.push_back(data);
      end else begin
         bSValid = sValid; bSData = data; bMReady = mReady; bFlush = flushIn;
         if (expectPush) bExpQ.push_back(data);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // FWFT monitor: a transfer happens whenever the consumer accepts a valid word.
   always @(negedge clk) begin
      if (rstn && !aFlush && aMValid && aMReady) begin
         aPopCnt++;
         if (aExpQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL fwftUnexpectedWord: actual %0h required none", aMData);
         end else begin
            checkOutput("fwftData", aMData, aExpQ.pop_front());
         end
      end
   end

   // Standard-mode monitor: every valid cycle presents one popped word.
   always @(negedge clk) begin
      if (rstn && bMValid) begin
         if (bExpQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL stdUnexpectedWord: actual %0h required none", bMData);
         end else begin
            checkOutput("stdData", bMData, bExpQ.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstn = 1'b1;
      applyStimulus(0, 0, '0, 0, 0, 0);
      applyStimulus(1, 0, '0, 0, 0, 0);
      #1 rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstSReady", aSReady, 0);
      checkOutput("rstMValid", aMValid, 0);
      checkOutput("rstMData", aMData, 0);
      checkOutput("rstLevel", aLevel, 0);
      checkOutput("rstFull", aFull, 0);
      checkOutput("rstEmpty", aEmpty, 1);
      checkOutput("rstAlmostFull", aAF, 0);
      checkOutput("rstAlmostEmpty", aAE, 1);
      checkOutput("rstUnderflow", bUnder, 0);
      rstn = 1'b1;
      #1;
      checkOutput("readyBeforeEdge", aSReady, 0);
      step();
      checkOutput("readyAfterEdge", aSReady, 1);
      checkOutput("readyAfterEdgeStd", bSReady, 1);

      $display("[TB] fill FWFT instance with 64 descending words");
      for (int i = 0; i < 64; i++) begin
         applyStimulus(0, 1, 46'h3FFF_FFFF_FFFF - 46'(i), 0, 0, 1);
         step();
         checkOutput("fillLevel", aLevel, i + 1);
         checkOutput("fillAlmostFull", aAF, (i + 1) >= 60);
         checkOutput("fillSReady", aSReady, (i + 1) < 64);
         checkOutput("fillMValid", aMValid, i >= 1);
      end
      checkOutput("fillFull", aFull, 1);
      checkOutput("headWord", aMData, 46'h3FFF_FFFF_FFFF);
      applyStimulus(0, 1, 46'h0000_0000_1234, 0, 0, 0);
      #1;
      checkOutput("overflowSReady", aSReady, 0);
      step();
      checkOutput("overflowLevel", aLevel, 64);

      $display("[TB] drain FWFT instance");
      applyStimulus(0, 0, '0, 1, 0, 0);
      for (int k = 0; k < 64; k++) begin
         step();
         checkOutput("drainLevel", aLevel, 63 - k);
         checkOutput("drainAlmostEmpty", aAE, (63 - k) <= 4);
         if (k == 0) checkOutput("readyAfterFullPop", aSReady, 1);
      end
      checkOutput("drainCount", aPopCnt, 64);
      checkOutput("drainMValid", aMValid, 0);
      checkOutput("drainEmpty", aEmpty, 1);
      checkOutput("fwftUnderflowTied", aUnder, 0);

      $display("[TB] pass-through at level 32");
      applyStimulus(0, 0, '0, 0, 0, 0);
      for (int i = 0; i < 32; i++) begin
         applyStimulus(0, 1, 46'h0000_0000_1000 + 46'(i), 0, 0, 1);
         step();
      end
      checkOutput("ptStartLevel", aLevel, 32);
      for (int j = 0; j < 100; j++) begin
         applyStimulus(0, 1, 46'h0000_0000_2000 + 46'(j), 1, 0, 1);
         step();
         checkOutput("ptLevel", aLevel, 32);
         checkOutput("ptSReady", aSReady, 1);
      end
      applyStimulus(0, 0, '0, 1, 0, 0);
      repeat (32) step();
      checkOutput("ptDrainLevel", aLevel, 0);
      checkOutput("ptQueueEmpty", aExpQ.size(), 0);

      $display("[TB] flush FWFT instance at level 10");
      applyStimulus(0, 0, '0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 1, 46'h0000_0000_3000 + 46'(i), 0, 0, 1);
         step();
      end
      checkOutput("preFlushLevel", aLevel, 10);
      applyStimulus(0, 1, 46'h3FFF_0000_0000, 1, 1, 0);
      step();
      applyStimulus(0, 0, '0, 0, 0, 0);
      aExpQ.delete();
      checkOutput("flushLevel", aLevel, 0);
      checkOutput("flushMValid", aMValid, 0);
      checkOutput("flushEmpty", aEmpty, 1);
      checkOutput("flushSReady", aSReady, 1);
      applyStimulus(0, 1, 46'h0000_0000_0ABC, 0, 0, 1);
      step();
      applyStimulus(0, 0, '0, 0, 0, 0);
      checkOutput("postFlushLevel", aLevel, 1);
      step();
      applyStimulus(0, 0, '0, 1, 0, 0);
      step();
      applyStimulus(0, 0, '0, 0, 0, 0);
      checkOutput("postFlushQueue", aExpQ.size(), 0);

      $display("[TB] standard mode reads and underflow");
      applyStimulus(1, 1, 46'h2AAA_5555_0001, 0, 0, 1);
      step();
      applyStimulus(1, 1, 46'h1555_AAAA_0002, 0, 0, 1);
      step();
      applyStimulus(1, 1, 46'h0123_4567_0003, 0, 0, 1);
      step();
      applyStimulus(1, 0, '0, 0, 0, 0);
      checkOutput("stdPreLevel", bLevel, 3);
      checkOutput("stdPreValid", bMValid, 0);
      applyStimulus(1, 0, '0, 1, 0, 0);
      for (int k = 0; k < 5; k++) begin
         step();
         checkOutput("stdValid", bMValid, k < 3);
         checkOutput("stdLevel", bLevel, (k < 3) ? (2 - k) : 0);
         checkOutput("stdUnderflow", bUnder, k >= 3);
      end
      applyStimulus(1, 0, '0, 0, 0, 0);
      step();
      checkOutput("stdIdleValid", bMValid, 0);
      checkOutput("stdStickyUnderflow", bUnder, 1);
      applyStimulus(1, 1, 46'h3FFF_0000_0000, 1, 1, 0);
      step();
      applyStimulus(1, 0, '0, 0, 0, 0);
      checkOutput("stdFlushUnderflow", bUnder, 0);
      checkOutput("stdFlushLevel", bLevel, 0);
      checkOutput("stdFlushValid", bMValid, 0);
      applyStimulus(1, 1, 46'h0000_0000_1357, 0, 0, 1);
      step();
      applyStimulus(1, 0, '0, 1, 0, 0);
      step();
      checkOutput("stdReadValid", bMValid, 1);
      applyStimulus(1, 0, '0, 0, 0, 0);
      step();
      checkOutput("stdReadDone", bMValid, 0);
      checkOutput("stdQueueEmpty", bExpQ.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
